// File: rtl/mem_pkg.sv
// Shared types for the memory-bus arbiter: bus owner and one memory request beat.
package mem_pkg;

  localparam int MEM_ADDR_WIDTH = 16;
  localparam int MEM_DATA_WIDTH = 16;

  typedef enum logic [0:0] {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic                      rd;
    logic                      wr;
    logic                      byt;
    logic [MEM_DATA_WIDTH-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_mux.sv
// Combinational 2:1 selector between the CPU and DMA request beats.
module mem_mux
  import mem_pkg::*;
(
  input  owner_e   sel_i,
  input  mem_req_t cpu_req_i,
  input  mem_req_t dma_req_i,
  output mem_req_t mem_req_o
);

  assign mem_req_o = (sel_i == OWN_DMA) ? dma_req_i : cpu_req_i;

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single-ported memory bus: CPU has fixed priority,
// DMA gets the bus when the CPU is idle or after MAX_WAIT refused cycles.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int MAX_WAIT   = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic                  cpu_byt,
  input  logic [15:0]           cpu_wdata,
  output logic [15:0]           cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dma_req,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic                  dma_wr,
  input  logic                  dma_byt,
  input  logic [15:0]           dma_wdata,
  output logic                  dma_gnt,
  output logic [15:0]           dma_rdata,
  output logic                  dma_rvalid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  mem_byt,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata
);

  localparam logic [7:0] WAIT_LIM  = 8'(MAX_WAIT);
  localparam logic [4:0] BURST_LIM = 5'(BURST_MAX);

  owner_e     state_q, state_d;
  owner_e     rtag_q, rtag_d;
  logic [7:0] wait_q, wait_d;
  logic [3:0] beat_q, beat_d;

  logic       cpu_busy;
  logic       dma_beat;
  logic [4:0] beat_next;
  owner_e     sel;
  mem_req_t   cpu_req;
  mem_req_t   dma_beat_req;
  mem_req_t   mem_req;

  assign cpu_busy  = cpu_rd | cpu_wr;
  assign beat_next = {1'b0, beat_q} + 5'd1;

  // Reset gates every strobe and handshake; addresses keep following the CPU.
  assign dma_beat = rst & (state_q == OWN_DMA) & dma_req;
  assign sel      = (rst && state_q == OWN_DMA) ? OWN_DMA : OWN_CPU;

  assign cpu_req.addr  = cpu_addr;
  assign cpu_req.rd    = cpu_rd & rst;
  assign cpu_req.wr    = cpu_wr & rst;
  assign cpu_req.byt   = cpu_byt;
  assign cpu_req.wdata = cpu_wdata;

  assign dma_beat_req.addr  = dma_addr;
  assign dma_beat_req.rd    = dma_beat & ~dma_wr;
  assign dma_beat_req.wr    = dma_beat & dma_wr;
  assign dma_beat_req.byt   = dma_byt;
  assign dma_beat_req.wdata = dma_wdata;

  mem_mux u_mem_mux (
    .sel_i     (sel),
    .cpu_req_i (cpu_req),
    .dma_req_i (dma_beat_req),
    .mem_req_o (mem_req)
  );

  assign mem_addr  = mem_req.addr;
  assign mem_rd    = mem_req.rd;
  assign mem_wr    = mem_req.wr;
  assign mem_byt   = mem_req.byt;
  assign mem_wdata = mem_req.wdata;

  assign cpu_stall  = rst & (state_q == OWN_DMA);
  assign dma_gnt    = dma_beat;
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;
  assign dma_rvalid = rst & (rtag_q == OWN_DMA);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    state_d = state_q;
    wait_d  = wait_q;
    beat_d  = beat_q;
    rtag_d  = (dma_beat && !dma_wr) ? OWN_DMA : OWN_CPU;

    case (state_q)
      OWN_CPU: begin
        if (!dma_req) begin
          wait_d = '0;
        end else begin
          if (cpu_busy && wait_q < WAIT_LIM) begin
            wait_d = wait_q + 8'd1;
          end
          if (!cpu_busy || wait_q >= WAIT_LIM) begin
            state_d = OWN_DMA;
          end
        end
      end

      OWN_DMA: begin
        if (dma_req && beat_next != BURST_LIM) begin
          beat_d = beat_next[3:0];
        end else begin
          // Burst complete or request withdrawn: hand the bus back with fresh counters.
          state_d = OWN_CPU;
          wait_d  = '0;
          beat_d  = '0;
        end
      end

      default: begin
        state_d = OWN_CPU;
        wait_d  = '0;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so all of them update from pre-edge values.
    if (!rst) begin
      state_q <= OWN_CPU;
      rtag_q  <= OWN_CPU;
      wait_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      rtag_q  <= rtag_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scripted vector table, corner-case
// sequences, then random traffic against a cycle-level reference model.
module tb_mem_arbiter;

  localparam int MAX_WAIT  = 8;
  localparam int BURST_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_rd, cpu_wr, cpu_byt, cpu_stall;
  logic        dma_req, dma_wr, dma_byt, dma_gnt, dma_rvalid;
  logic [15:0] dma_addr, dma_wdata, dma_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_byt;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(16), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_byt(cpu_byt),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wr(dma_wr), .dma_byt(dma_byt),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_byt(mem_byt),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory device on the bus plus the reference copy the model maintains.
  logic [15:0] dev_mem [0:32767];
  logic [15:0] ref_mem [0:32767];
  logic [15:0] dev_rdata = 16'h0;
  assign mem_rdata = dev_rdata;

  function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] wd,
                                        input logic byt, input logic lane);
    if (!byt) return wd;
    return lane ? {wd[15:8], old_w[7:0]} : {old_w[15:8], wd[7:0]};
  endfunction

  always @(posedge clk) begin
    if (mem_rd) dev_rdata <= dev_mem[mem_addr[15:1]];
    if (mem_wr) dev_mem[mem_addr[15:1]] <= merge(dev_mem[mem_addr[15:1]], mem_wdata, mem_byt, mem_addr[0]);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [15:0] cpu_addr;
    logic        dma_req;
    logic        dma_wr;
    logic [15:0] dma_addr;
    logic [15:0] dma_wdata;
    logic        stall;
    logic        gnt;
    logic        m_rd;
    logic        m_wr;
    logic [15:0] m_addr;
    logic        rvalid;
    logic        chk_rdata;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs [13];

  // Reference model state (random phase).
  bit          m_owns;
  int          m_refused;
  int          m_beats;
  bit          m_prev_rd;
  bit          m_prev_dma_rd;
  logic [15:0] m_prev_data;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          first_gnt;
    logic [15:0] addr_c9;
    bit          pat_gnt [7];
    bit          pat_stall [7];
    bit          e_stall, e_gnt, e_rd, e_wr, e_rv, e_byt;
    logic [15:0] e_addr, e_wdata;
    bit          saw_gnt;

    for (int i = 0; i < 32768; i++) begin
      dev_mem[i] = 16'(i * 7) ^ 16'h5A5A;
      ref_mem[i] = 16'(i * 7) ^ 16'h5A5A;
    end
    dev_mem[16'h4000 >> 1] = 16'hBEEF;
    dev_mem[16'h0200 >> 1] = 16'h1234;

    rst = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_byt = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    dma_req = 1'b0; dma_wr = 1'b0; dma_byt = 1'b0; dma_addr = 16'h0; dma_wdata = 16'h0;
    tick();

    // rst, crd, cwr, caddr, dreq, dwr, daddr, dwdata | stall, gnt, mrd, mwr, maddr, rvalid, chk, rdata
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'h4000, 1'b1, 1'b1, 16'h0100, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4000, 1'b0, 1'b0, 16'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'h4000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4000, 1'b0, 1'b0, 16'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h4002, 1'b1, 1'b1, 16'h0100, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4002, 1'b0, 1'b1, 16'hBEEF};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h4002, 1'b1, 1'b1, 16'h0100, 16'h1111, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h4000, 1'b1, 1'b1, 16'h0102, 16'h2222, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0102, 1'b0, 1'b0, 16'h0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'h4000, 1'b1, 1'b1, 16'h0104, 16'h3333, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0104, 1'b0, 1'b0, 16'h0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h4002, 1'b1, 1'b1, 16'h0106, 16'h4444, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0106, 1'b0, 1'b0, 16'h0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'h4000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4000, 1'b0, 1'b0, 16'h0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h4004, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4004, 1'b0, 1'b1, 16'hBEEF};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'h4004, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0, 16'h0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h4004, 1'b0, 1'b0, 16'h0200, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0200, 1'b1, 1'b1, 16'h1234};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 16'h4000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4000, 1'b0, 1'b0, 16'h0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 16'h4000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4000, 1'b0, 1'b1, 16'hBEEF};

    for (int i = 0; i < 13; i++) begin
      rst = vecs[i].rst; cpu_rd = vecs[i].cpu_rd; cpu_wr = vecs[i].cpu_wr; cpu_addr = vecs[i].cpu_addr;
      dma_req = vecs[i].dma_req; dma_wr = vecs[i].dma_wr; dma_addr = vecs[i].dma_addr; dma_wdata = vecs[i].dma_wdata;
      @(negedge clk);
      check($sformatf("vec%0d cpu_stall", i), cpu_stall, vecs[i].stall);
      check($sformatf("vec%0d dma_gnt", i), dma_gnt, vecs[i].gnt);
      check($sformatf("vec%0d mem_rd", i), mem_rd, vecs[i].m_rd);
      check($sformatf("vec%0d mem_wr", i), mem_wr, vecs[i].m_wr);
      check($sformatf("vec%0d dma_rvalid", i), dma_rvalid, vecs[i].rvalid);
      if (vecs[i].m_rd || vecs[i].m_wr || !vecs[i].stall)
        check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].m_addr);
      if (vecs[i].chk_rdata) begin
        check($sformatf("vec%0d cpu_rdata", i), cpu_rdata, vecs[i].rdata);
        if (vecs[i].rvalid) check($sformatf("vec%0d dma_rdata", i), dma_rdata, vecs[i].rdata);
      end
      tick();
    end
    check("burst word 0100", dev_mem[16'h0100 >> 1], 16'h1111);
    check("burst word 0102", dev_mem[16'h0102 >> 1], 16'h2222);
    check("burst word 0104", dev_mem[16'h0104 >> 1], 16'h3333);
    check("burst word 0106", dev_mem[16'h0106 >> 1], 16'h4444);

    // Starvation: CPU busy every cycle, DMA request held from cycle 1.
    rst = 1'b0; tick(); rst = 1'b1;
    first_gnt = 0;
    addr_c9 = 16'h4000 + 16'd18;
    dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 16'h0300; dma_wdata = 16'hC0DE;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      cpu_rd = 1'b1; cpu_addr = 16'h4000 + 16'(2 * cyc);
      @(negedge clk);
      if (cyc == 9) begin
        check("starve c9 cpu_stall", cpu_stall, 1'b0);
        check("starve c9 mem_rd", mem_rd, 1'b1);
        check("starve c9 mem_addr", mem_addr, addr_c9);
      end
      if (dma_gnt) begin
        first_gnt = cyc;
        break;
      end
      tick();
    end
    check("starve first grant cycle", first_gnt, 10);
    tick(); dma_req = 1'b0; cpu_rd = 1'b0;
    tick(); tick();

    // DMA drops after 2 of 4 beats.
    dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 16'h0500; dma_wdata = 16'hAAAA;
    @(negedge clk);
    check("drop c0 dma_gnt", dma_gnt, 1'b0);
    tick();
    @(negedge clk);
    check("drop c1 dma_gnt", dma_gnt, 1'b1);
    check("drop c1 mem_addr", mem_addr, 16'h0500);
    tick(); dma_addr = 16'h0502; dma_wdata = 16'hBBBB;
    @(negedge clk);
    check("drop c2 dma_gnt", dma_gnt, 1'b1);
    tick(); dma_req = 1'b0;
    @(negedge clk);
    check("drop idle cpu_stall", cpu_stall, 1'b1);
    check("drop idle strobes", {mem_rd, mem_wr}, 2'b00);
    check("drop idle dma_gnt", dma_gnt, 1'b0);
    tick();
    @(negedge clk);
    check("drop resume cpu_stall", cpu_stall, 1'b0);
    tick();
    check("drop word 0500", dev_mem[16'h0500 >> 1], 16'hAAAA);
    check("drop word 0502", dev_mem[16'h0502 >> 1], 16'hBBBB);

    // Next burst after the early drop must get a full BURST_MAX beats.
    pat_gnt   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    pat_stall = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    dma_req = 1'b1; dma_addr = 16'h0600; dma_wdata = 16'h6666;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check($sformatf("reburst c%0d dma_gnt", k), dma_gnt, pat_gnt[k]);
      check($sformatf("reburst c%0d cpu_stall", k), cpu_stall, pat_stall[k]);
      tick();
    end
    dma_req = 1'b0; tick(); tick();

    // Reset in the middle of a DMA read burst.
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 16'h0200;
    tick();
    @(negedge clk);
    check("rstmid c1 dma_gnt", dma_gnt, 1'b1);
    check("rstmid c1 mem_rd", mem_rd, 1'b1);
    tick(); rst = 1'b0;
    @(negedge clk);
    check("rstmid c2 cpu_stall", cpu_stall, 1'b0);
    check("rstmid c2 dma_gnt", dma_gnt, 1'b0);
    check("rstmid c2 dma_rvalid", dma_rvalid, 1'b0);
    check("rstmid c2 strobes", {mem_rd, mem_wr}, 2'b00);
    tick(); rst = 1'b1;
    @(negedge clk);
    check("rstmid c3 dma_gnt", dma_gnt, 1'b0);
    check("rstmid c3 cpu_stall", cpu_stall, 1'b0);
    check("rstmid c3 dma_rvalid", dma_rvalid, 1'b0);
    tick();
    @(negedge clk);
    check("rstmid c4 dma_gnt", dma_gnt, 1'b1);
    tick(); dma_req = 1'b0; tick(); tick();

    // Random traffic in the 8000h region against the reference model.
    rst = 1'b0; tick(); rst = 1'b1;
    m_owns = 1'b0; m_refused = 0; m_beats = 0; m_prev_rd = 1'b0; m_prev_dma_rd = 1'b0; m_prev_data = 16'h0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!rst) begin
        e_stall = 1'b0; e_gnt = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_rv = 1'b0;
        e_addr = cpu_addr; e_byt = cpu_byt; e_wdata = cpu_wdata;
      end else if (!m_owns) begin
        e_stall = 1'b0; e_gnt = 1'b0; e_rd = cpu_rd; e_wr = cpu_wr; e_rv = m_prev_dma_rd;
        e_addr = cpu_addr; e_byt = cpu_byt; e_wdata = cpu_wdata;
      end else begin
        e_stall = 1'b1; e_gnt = dma_req; e_rd = dma_req & ~dma_wr; e_wr = dma_req & dma_wr; e_rv = m_prev_dma_rd;
        e_addr = dma_addr; e_byt = dma_byt; e_wdata = dma_wdata;
      end
      check("rand cpu_stall", cpu_stall, e_stall);
      check("rand dma_gnt", dma_gnt, e_gnt);
      check("rand mem_rd", mem_rd, e_rd);
      check("rand mem_wr", mem_wr, e_wr);
      check("rand dma_rvalid", dma_rvalid, e_rv);
      if (e_rd || e_wr || !e_stall) check("rand mem_addr", mem_addr, e_addr);
      if (e_wr) check("rand mem_wdata", {mem_byt, mem_wdata}, {e_byt, e_wdata});
      if (m_prev_rd) check("rand cpu_rdata", cpu_rdata, m_prev_data);
      if (e_rv) check("rand dma_rdata", dma_rdata, m_prev_data);

      m_prev_rd = e_rd;
      m_prev_dma_rd = e_rd && m_owns && rst;
      if (e_rd) m_prev_data = ref_mem[e_addr[15:1]];
      if (e_wr) ref_mem[e_addr[15:1]] = merge(ref_mem[e_addr[15:1]], e_wdata, e_byt, e_addr[0]);
      if (!rst) begin
        m_owns = 1'b0; m_refused = 0; m_beats = 0;
      end else if (!m_owns) begin
        if (!dma_req) m_refused = 0;
        else if (!(cpu_rd || cpu_wr) || m_refused == MAX_WAIT) begin m_owns = 1'b1; m_beats = 0; end
        else m_refused++;
      end else begin
        if (dma_req) m_beats++;
        if (!dma_req || m_beats == BURST_MAX) begin m_owns = 1'b0; m_refused = 0; m_beats = 0; end
      end
      saw_gnt = dma_gnt;
      tick();

      rst = ($urandom_range(0, 63) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2: begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
        3, 4, 5, 6: begin cpu_rd = 1'b1; cpu_wr = 1'b0; end
        default: begin cpu_rd = 1'b0; cpu_wr = 1'b1; end
      endcase
      cpu_addr = 16'h8000 | 16'($urandom_range(0, 63));
      cpu_byt = ($urandom_range(0, 3) == 0);
      cpu_wdata = 16'($urandom);
      if ((!dma_req && $urandom_range(0, 3) == 0) || (dma_req && saw_gnt)) begin
        dma_req = !(dma_req && $urandom_range(0, 4) == 0);
        dma_wr = $urandom_range(0, 1) == 1;
        dma_byt = ($urandom_range(0, 3) == 0);
        dma_addr = 16'h8000 | 16'($urandom_range(0, 63));
        dma_wdata = 16'($urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
